// File: rtl/jtag_tap_param_if.sv
// jtag_tap_param_if: pad-side and user-channel signals of the TAP controller
interface jtag_tap_param_if #(
  parameter int IR_WIDTH = 5,
  parameter int NUM_CH   = 2
);
  logic                tms_i;
  logic                td_i;
  logic                td_o;
  logic                tdo_oe_o;
  logic [IR_WIDTH-1:0] ir_o;
  logic [3:0]          tap_state_o;
  logic [NUM_CH-1:0]   dr_sel_o;
  logic                capture_dr_o;
  logic                shift_dr_o;
  logic                update_dr_o;
  logic [NUM_CH-1:0]   dr_tdo_i;
  modport master (
    output tms_i, td_i, dr_tdo_i,
    input  td_o, tdo_oe_o, ir_o, tap_state_o, dr_sel_o, capture_dr_o, shift_dr_o, update_dr_o
  );
  modport slave (
    input  tms_i, td_i, dr_tdo_i,
    output td_o, tdo_oe_o, ir_o, tap_state_o, dr_sel_o, capture_dr_o, shift_dr_o, update_dr_o
  );
endinterface

// File: rtl/jtag_tap_param.sv
// jtag_tap_param: IEEE 1149.1 TAP controller with IDCODE, BYPASS and NUM_CH user DR channels
module jtag_tap_param #(
  parameter int              IR_WIDTH   = 5,
  parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001,
  parameter int              NUM_CH     = 2,
  parameter int              USER_BASE  = 'h10
) (
  input logic             tck_i,
  input logic             trst_i,
  jtag_tap_param_if.slave s
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } state_t;
  localparam logic [IR_WIDTH-1:0] IDC = IR_WIDTH'(1);
  state_t              state, nxt;
  logic [IR_WIDTH-1:0] ir, ir_sh;
  logic [31:0]         id_sh;
  logic                byp;
  logic [NUM_CH-1:0]   dr_sel;
  logic                is_idc, is_user;
  always_comb begin
    nxt = state;
    case (state)
      TLR:     nxt = s.tms_i ? TLR    : RTI;
      RTI:     nxt = s.tms_i ? SEL_DR : RTI;
      SEL_DR:  nxt = s.tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  nxt = s.tms_i ? EX1_DR : SH_DR;
      SH_DR:   nxt = s.tms_i ? EX1_DR : SH_DR;
      EX1_DR:  nxt = s.tms_i ? UPD_DR : PA_DR;
      PA_DR:   nxt = s.tms_i ? EX2_DR : PA_DR;
      EX2_DR:  nxt = s.tms_i ? UPD_DR : SH_DR;
      UPD_DR:  nxt = s.tms_i ? SEL_DR : RTI;
      SEL_IR:  nxt = s.tms_i ? TLR    : CAP_IR;
      CAP_IR:  nxt = s.tms_i ? EX1_IR : SH_IR;
      SH_IR:   nxt = s.tms_i ? EX1_IR : SH_IR;
      EX1_IR:  nxt = s.tms_i ? UPD_IR : PA_IR;
      PA_IR:   nxt = s.tms_i ? EX2_IR : PA_IR;
      EX2_IR:  nxt = s.tms_i ? UPD_IR : SH_IR;
      default: nxt = s.tms_i ? SEL_DR : RTI;
    endcase
  end
  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      state <= TLR;
      ir    <= IDC;
      ir_sh <= '0;
      id_sh <= '0;
      byp   <= 1'b0;
    end else begin
      state <= nxt;
      ir    <= (nxt == TLR) ? IDC : (state == UPD_IR) ? ir_sh : ir;
      if (state == CAP_IR) ir_sh <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
      if (state == SH_IR) ir_sh <= {s.td_i, ir_sh[IR_WIDTH-1:1]};
      if (state == CAP_DR && is_idc) id_sh <= IDCODE_VAL;
      if (state == SH_DR && is_idc) id_sh <= {s.td_i, id_sh[31:1]};
      if (state == CAP_DR && !is_idc && !is_user) byp <= 1'b0;
      if (state == SH_DR && !is_idc && !is_user) byp <= s.td_i;
    end
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_sel
    assign dr_sel[k] = (ir == IR_WIDTH'(USER_BASE + k));
  end
  assign is_idc         = (ir == IDC);
  assign is_user        = |dr_sel;
  assign s.ir_o         = ir;
  assign s.tap_state_o  = state;
  assign s.dr_sel_o     = dr_sel;
  assign s.tdo_oe_o     = (state == SH_IR) || (state == SH_DR);
  assign s.capture_dr_o = (state == CAP_DR) && is_user;
  assign s.shift_dr_o   = (state == SH_DR) && is_user;
  assign s.update_dr_o  = (state == UPD_DR) && is_user;
  // DR source follows the active instruction; unknown codes fall through to BYPASS
  assign s.td_o = (state == SH_IR) ? ir_sh[0] :
                  (state == SH_DR) ? (is_idc ? id_sh[0] : is_user ? |(dr_sel & s.dr_tdo_i) : byp) :
                  1'b0;
endmodule
